// File: rtl/complex_divider_pkg.sv
// -----------------------------------------------------------------------------
// complex_div_pkg
//   Shared types and width helpers for the sequential complex divider.
//   - state_e      : top-level FSM states (IDLE -> MUL -> DIV -> IDLE)
//   - prod_sel_e   : which operand pair the shared multiplier uses on each
//                    product edge, and which accumulator receives it
//   - calc_*       : derived widths from the operand width W and FRAC
// -----------------------------------------------------------------------------
package complex_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    // Product schedule; the encoding doubles as the product counter value k.
    typedef enum logic [2:0] {
        SEL_CC = 3'd0,  // den    += c*c
        SEL_DD = 3'd1,  // den    += d*d
        SEL_AC = 3'd2,  // num_re += a*c
        SEL_BD = 3'd3,  // num_re += b*d
        SEL_BC = 3'd4,  // num_im += b*c
        SEL_AD = 3'd5   // num_im -= a*d
    } prod_sel_e;

    localparam int W_DEFAULT    = 8;
    localparam int FRAC_DEFAULT = 4;

    // Product / denominator width.
    function automatic int calc_pw(input int w);
        return 2 * w;
    endfunction

    // Signed numerator accumulator width.
    function automatic int calc_nw(input int w);
        return 2 * w + 1;
    endfunction

    // Signed quotient output width.
    function automatic int calc_qw(input int w, input int frac);
        return w + 1 + frac;
    endfunction

    // Restoring-division iteration count (one quotient bit per edge).
    function automatic int calc_n(input int w, input int frac);
        return 2 * w + frac;
    endfunction

endpackage

// File: rtl/complex_divider_div.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned sequential restoring divider, one quotient bit per clock edge.
//   The dividend register shifts out its MSB into the partial remainder and
//   shifts the new quotient bit in at the LSB, so after ITER steps it holds
//   the quotient of (dividend >> (DW-ITER)) / divisor.
//
//   Ports:
//     clk_i       clock, rising edge
//     rst_i       asynchronous active-high reset
//     start_i     load dividend/divisor and begin ITER steps
//     dividend_i  unsigned dividend (DW bits)
//     divisor_i   unsigned divisor (VW bits)
//     quotient_o  low QOW bits of the quotient *after* the step taken at the
//                 coming edge; final when done_o is high
//     done_o      high in the cycle whose rising edge performs the last step
//
//   A zero divisor yields an all-ones quotient; the caller masks it.
// -----------------------------------------------------------------------------
module seq_restoring_divider
    import complex_div_pkg::*;
#(
    parameter int DW   = 20,
    parameter int VW   = 16,
    parameter int ITER = 20,
    parameter int QOW  = 12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [DW-1:0]   dividend_i,
    input  logic [VW-1:0]   divisor_i,
    output logic [QOW-1:0]  quotient_o,
    output logic            done_o
);

    localparam int CW = $clog2(ITER + 1);

    logic [VW:0]   rem_q;
    logic [DW-1:0] dq_q;
    logic [VW-1:0] dv_q;
    logic [CW-1:0] cnt_q;

    logic [VW:0]   rem_sh;
    logic [VW:0]   rem_d;
    logic [DW-1:0] dq_d;
    logic          ge;

    // rem_q carries one spare bit so the true shifted remainder is never
    // truncated; it can only become set when the divisor is zero.
    always_comb begin
        rem_sh = {rem_q[VW-1:0], dq_q[DW-1]};
        ge     = rem_q[VW] | (rem_sh >= {1'b0, dv_q});
        rem_d  = ge ? (rem_sh - {1'b0, dv_q}) : rem_sh;
        dq_d   = {dq_q[DW-2:0], ge};
    end

    assign quotient_o = dq_d[QOW-1:0];
    assign done_o     = (cnt_q == CW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            dq_q  <= '0;
            dv_q  <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            dq_q  <= dividend_i;
            dv_q  <= divisor_i;
            cnt_q <= CW'(ITER);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/complex_divider.sv
// -----------------------------------------------------------------------------
// complex_divider
//   Sequential complex divider: Q = (a+jb)/(c+jd)
//                                  = ((ac+bd) + j(bc-ad)) / (c^2+d^2)
//   One shared WxW signed multiplier is used over six product edges, then two
//   lockstep restoring dividers produce the fixed-point quotients with FRAC
//   fractional bits, truncated toward zero.
//
//   Ports:
//     CLK, RST              clock (rising) / asynchronous active-high reset
//     IN_VALID, IN_READY    operand handshake
//     OP_1..OP_4            a, b, c, d (signed, W bits)
//     OUT_VALID             one-cycle pulse with a new result
//     REAL_PART_Q           signed real quotient (W+1+FRAC bits)
//     IMAG_PART_Q           signed imag quotient (W+1+FRAC bits)
//     DIV_BY_ZERO           c = d = 0 for the current result
//     DBG_STATE             current FSM state, for observation only
//
//   Handshake: operands are captured on the rising edge where
//   IN_VALID && IN_READY; IN_READY is high exactly when the FSM is IDLE
//   (including the OUT_VALID cycle). IN_VALID while busy is ignored and OP_*
//   are not sampled. Results and DIV_BY_ZERO hold until the next OUT_VALID.
//
//   Latency: accept edge + 6 product edges + 2W+FRAC divide edges; OUT_VALID
//   is high in the cycle after the last divide edge.
// -----------------------------------------------------------------------------
module complex_divider
    import complex_div_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic signed [W-1:0]    OP_1,
    input  logic signed [W-1:0]    OP_2,
    input  logic signed [W-1:0]    OP_3,
    input  logic signed [W-1:0]    OP_4,
    output logic                   OUT_VALID,
    output logic signed [W+FRAC:0] REAL_PART_Q,
    output logic signed [W+FRAC:0] IMAG_PART_Q,
    output logic                   DIV_BY_ZERO,
    output state_e                 DBG_STATE
);

    localparam int PW = calc_pw(W);
    localparam int NW = calc_nw(W);
    localparam int QW = calc_qw(W, FRAC);
    localparam int N  = calc_n(W, FRAC);

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    state_e               state_q;
    prod_sel_e            k_q;
    logic signed [W-1:0]  a_q, b_q, c_q, d_q;
    logic [PW-1:0]        den_q;
    logic signed [NW-1:0] num_re_q, num_im_q;
    logic                 neg_re_q, neg_im_q, dbz_q;

    logic                 out_valid_q;
    logic [QW-1:0]        real_q, imag_q;
    logic                 dbz_out_q;

    // ------------------------------------------------------------------
    // Shared multiplier and accumulator next-values
    // ------------------------------------------------------------------
    logic signed [W-1:0]  mul_a, mul_b;
    logic signed [PW-1:0] prod;
    logic [NW-1:0]        prod_ext;
    logic [PW-1:0]        den_d;
    logic signed [NW-1:0] num_re_d, num_im_d;

    always_comb begin
        mul_a = c_q;
        mul_b = c_q;
        case (k_q)
            SEL_CC: begin mul_a = c_q; mul_b = c_q; end
            SEL_DD: begin mul_a = d_q; mul_b = d_q; end
            SEL_AC: begin mul_a = a_q; mul_b = c_q; end
            SEL_BD: begin mul_a = b_q; mul_b = d_q; end
            SEL_BC: begin mul_a = b_q; mul_b = c_q; end
            SEL_AD: begin mul_a = a_q; mul_b = d_q; end
            default: begin mul_a = c_q; mul_b = c_q; end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {prod[PW-1], prod};

    always_comb begin
        den_d    = den_q;
        num_re_d = num_re_q;
        num_im_d = num_im_q;
        case (k_q)
            SEL_CC, SEL_DD: den_d    = den_q + prod;      // squares are >= 0
            SEL_AC, SEL_BD: num_re_d = num_re_q + prod_ext;
            SEL_BC:         num_im_d = num_im_q + prod_ext;
            SEL_AD:         num_im_d = num_im_q - prod_ext;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider load: magnitudes of the final numerators (taken from the
    // k=5 next-values), scaled by 2^FRAC. |num| <= 2^(2W-1) fits PW bits.
    // ------------------------------------------------------------------
    logic [PW-1:0] abs_re, abs_im;
    logic          div_start;
    logic [QW-2:0] quo_re, quo_im;
    logic          done_re, done_im, div_done;

    assign abs_re    = num_re_d[NW-1] ? PW'(-num_re_d) : num_re_d[PW-1:0];
    assign abs_im    = num_im_d[NW-1] ? PW'(-num_im_d) : num_im_d[PW-1:0];
    assign div_start = (state_q == MUL) && (k_q == SEL_AD);

    seq_restoring_divider #(
        .DW   (N),
        .VW   (PW),
        .ITER (N),
        .QOW  (QW - 1)
    ) u_div_re (
        .clk_i      (CLK),
        .rst_i      (RST),
        .start_i    (div_start),
        .dividend_i ({abs_re, {FRAC{1'b0}}}),
        .divisor_i  (den_d),
        .quotient_o (quo_re),
        .done_o     (done_re)
    );

    seq_restoring_divider #(
        .DW   (N),
        .VW   (PW),
        .ITER (N),
        .QOW  (QW - 1)
    ) u_div_im (
        .clk_i      (CLK),
        .rst_i      (RST),
        .start_i    (div_start),
        .dividend_i ({abs_im, {FRAC{1'b0}}}),
        .divisor_i  (den_d),
        .quotient_o (quo_im),
        .done_o     (done_im)
    );

    assign div_done = done_re & done_im;

    // Reapply the numerator sign; a zero magnitude stays +0.
    logic [QW-1:0] res_re, res_im;
    assign res_re = neg_re_q ? (QW'(0) - {1'b0, quo_re}) : {1'b0, quo_re};
    assign res_im = neg_im_q ? (QW'(0) - {1'b0, quo_im}) : {1'b0, quo_im};

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            k_q         <= SEL_CC;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            den_q       <= '0;
            num_re_q    <= '0;
            num_im_q    <= '0;
            neg_re_q    <= 1'b0;
            neg_im_q    <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            real_q      <= '0;
            imag_q      <= '0;
            dbz_out_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q      <= OP_1;
                        b_q      <= OP_2;
                        c_q      <= OP_3;
                        d_q      <= OP_4;
                        den_q    <= '0;
                        num_re_q <= '0;
                        num_im_q <= '0;
                        k_q      <= SEL_CC;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    den_q    <= den_d;
                    num_re_q <= num_re_d;
                    num_im_q <= num_im_d;
                    if (k_q == SEL_AD) begin
                        neg_re_q <= num_re_d[NW-1];
                        neg_im_q <= num_im_d[NW-1];
                        dbz_q    <= (den_d == '0);
                        state_q  <= DIV;
                    end else begin
                        k_q <= prod_sel_e'(k_q + 3'd1);
                    end
                end
                DIV: begin
                    if (div_done) begin
                        real_q      <= dbz_q ? '0 : res_re;
                        imag_q      <= dbz_q ? '0 : res_im;
                        dbz_out_q   <= dbz_q;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY    = (state_q == IDLE);
    assign OUT_VALID   = out_valid_q;
    assign REAL_PART_Q = real_q;
    assign IMAG_PART_Q = imag_q;
    assign DIV_BY_ZERO = dbz_out_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_complex_divider.sv
module tb_complex_divider;
    import complex_div_pkg::*;

    localparam int W    = 8;
    localparam int FRAC = 4;
    localparam int QW   = W + 1 + FRAC;
    localparam int LAT  = 6 + 2 * W + FRAC;   // edges from accept to result
    localparam int N_RND = 1000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  op_1, op_2, op_3, op_4;
    logic                 out_valid;
    logic signed [QW-1:0] real_part_q, imag_part_q;
    logic                 div_by_zero;
    state_e               dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    complex_divider #(.W(W), .FRAC(FRAC)) dut (
        .CLK         (clk),
        .RST         (rst),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .OP_1        (op_1),
        .OP_2        (op_2),
        .OP_3        (op_3),
        .OP_4        (op_4),
        .OUT_VALID   (out_valid),
        .REAL_PART_Q (real_part_q),
        .IMAG_PART_Q (imag_part_q),
        .DIV_BY_ZERO (div_by_zero),
        .DBG_STATE   (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2*QW:0] exp_q[$];   // {dbz, re, im}

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sign(num) * floor(|num| * 2^FRAC / den), zero den -> 0/0/dbz.
    function automatic logic [2*QW:0] model(input int a, input int b, input int c, input int d);
        int den, nr, ni, mr, mi;
        logic [QW-1:0] r, i;
        den = c * c + d * d;
        nr  = a * c + b * d;
        ni  = b * c - a * d;
        if (den == 0) return {1'b1, {(2*QW){1'b0}}};
        mr = ((nr < 0 ? -nr : nr) * (1 << FRAC)) / den;
        mi = ((ni < 0 ? -ni : ni) * (1 << FRAC)) / den;
        if (nr < 0) mr = -mr;
        if (ni < 0) mi = -mi;
        r = QW'(mr);
        i = QW'(mi);
        return {1'b0, r, i};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_ops(input int a, input int b, input int c, input int d);
        op_1 = W'(a);
        op_2 = W'(b);
        op_3 = W'(c);
        op_4 = W'(d);
    endtask

    // Presents operands with IN_VALID for one accept edge; returns just after it.
    task automatic accept_op(input int a, input int b, input int c, input int d);
        @(negedge clk);
        drive_ops(a, b, c, d);
        in_valid = 1'b1;
        check_val("ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called right after an accept edge; lat = number of edges until the
    // OUT_VALID cycle, or -1 if it never came within the budget.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int e = 0; e <= 60; e++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic run_directed(input string tag, input int a, input int b, input int c,
                                input int d, input int exp_re, input int exp_im,
                                input int exp_dbz);
        int lat;
        accept_op(a, b, c, d);
        wait_result(lat);
        check_val({tag, "_latency"}, lat, LAT);
        check_val({tag, "_re"}, real_part_q, exp_re);
        check_val({tag, "_im"}, imag_part_q, exp_im);
        check_val({tag, "_dbz"}, div_by_zero, exp_dbz);
        check_val({tag, "_ready_at_out"}, in_ready, 1);
        @(negedge clk);
        check_val({tag, "_valid_width"}, out_valid, 0);
        check_val({tag, "_re_hold"}, real_part_q, exp_re);
    endtask

    task automatic gen_random();
        int a, b, c, d;
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        c = int'($urandom_range(0, 255)) - 128;
        d = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 9) == 0) begin
            c = 0;
            d = 0;
        end
        drive_ops(a, b, c, d);
        exp_q.push_back(model(a, b, c, d));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int seen;
        logic [2*QW:0] e;

        rst      = 1'b1;
        in_valid = 1'b0;
        drive_ops(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_ready", in_ready, 1);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_re", real_part_q, 0);
        check_val("rst_im", imag_part_q, 0);
        check_val("rst_dbz", div_by_zero, 0);
        check_val("rst_state", dbg_state, IDLE);
        rst = 1'b0;

        // Directed vectors, expectations worked by hand.
        run_directed("basic",     3,    4,    1, 2,    35,    -6, 0);
        run_directed("dbz",       5,    5,    0, 0,     0,     0, 1);
        run_directed("dbz_clear", 3,    4,    1, 2,    35,    -6, 0);
        run_directed("zero_all",  0,    0,    0, 0,     0,     0, 1);
        run_directed("pos_ext",   127,  127,  0, 1,  2032, -2032, 0);
        run_directed("neg_ext",  -128, -128,  1, 0, -2048, -2048, 0);
        run_directed("trunc_re", -1,    0,    3, 0,    -5,     0, 0);
        run_directed("trunc_im",  1,    0,    0, 3,     0,    -5, 0);
        run_directed("third",     1,    0,    3, 0,     5,     0, 0);
        run_directed("int_div",   9,    9,    3, 0,    48,    48, 0);

        // Busy: second operand set held on the bus during the operation.
        @(negedge clk);
        drive_ops(3, 4, 1, 2);
        in_valid = 1'b1;
        @(posedge clk);
        #1 drive_ops(9, 9, 3, 0);
        lat = -1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            check_val("busy_ready_low", in_ready, 0);
        end
        check_val("busy_latency", lat, LAT);
        check_val("busy_re", real_part_q, 35);
        check_val("busy_im", imag_part_q, -6);
        check_val("busy_ready_at_out", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat);
        check_val("busy2_latency", lat, LAT);
        check_val("busy2_re", real_part_q, 48);
        check_val("busy2_im", imag_part_q, 48);
        check_val("busy2_dbz", div_by_zero, 0);

        // Reset in the middle of an operation.
        accept_op(3, 4, 1, 2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_valid", out_valid, 0);
        check_val("abort_re", real_part_q, 0);
        check_val("abort_im", imag_part_q, 0);
        check_val("abort_dbz", div_by_zero, 0);
        check_val("abort_ready", in_ready, 1);
        check_val("abort_state", dbg_state, IDLE);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("abort_no_pulse", seen, 0);
        run_directed("after_reset", 3, 4, 1, 2, 35, -6, 0);

        // Back-to-back with IN_VALID held high, random signed operands.
        @(negedge clk);
        gen_random();
        in_valid = 1'b1;
        for (int i = 0; i < N_RND; i++) begin
            check_val("rnd_ready", in_ready, 1);
            @(posedge clk);
            wait_result(lat);
            check_val("rnd_latency", lat, LAT);
            if (exp_q.size() == 0) begin
                check_val("rnd_queue_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_val("rnd_re", real_part_q, $signed(e[2*QW-1:QW]));
                check_val("rnd_im", imag_part_q, $signed(e[QW-1:0]));
                check_val("rnd_dbz", div_by_zero, e[2*QW]);
            end
            if (i < N_RND - 1) gen_random();
            else in_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound for the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
